mybullet_app: RTL and testbench

MYBULLET_APP -- requirements
Module: mybullet_app

---
 rtl/mybullet_app_pkg.sv | 26 ++
 rtl/mybullet_app_edge_det.sv | 28 ++
 rtl/mybullet_app.sv | 123 ++++++++++++
 tb/tb_mybullet_app.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mybullet_app_pkg.sv
// Shared game package: heading encodings, park cell and playfield defaults.
// Bullet headings alias the tank headings so both blocks always agree.
package mybullet_app_pkg;

    localparam logic [1:0] TANK_DIR_UP    = 2'b00;
    localparam logic [1:0] TANK_DIR_DOWN  = 2'b01;
    localparam logic [1:0] TANK_DIR_LEFT  = 2'b10;
    localparam logic [1:0] TANK_DIR_RIGHT = 2'b11;

    localparam logic [1:0] DIR_UP    = TANK_DIR_UP;
    localparam logic [1:0] DIR_DOWN  = TANK_DIR_DOWN;
    localparam logic [1:0] DIR_LEFT  = TANK_DIR_LEFT;
    localparam logic [1:0] DIR_RIGHT = TANK_DIR_RIGHT;

    localparam logic [4:0] PARK = 5'd31;

    localparam int X_MAX_DEF = 15;
    localparam int Y_MAX_DEF = 19;
    localparam int RANGE_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } bul_state_t;

endpackage

// File: rtl/mybullet_app_edge_det.sv
// Rising-edge detector: one-cycle registered pulse the cycle after din goes 0->1.
// The first sample after reset only primes the history, so a level already high is not an edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic r_hist;
    logic r_armed;
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_hist  <= din;
            r_armed <= 1'b1;
            r_pulse <= din & ~r_hist & r_armed;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/mybullet_app.sv
// Player bullet: IDLE/FLY FSM with a registered position datapath stepped on 4 Hz ticks.
// Optional flight-range limit enabled by defining MYBUL_RANGE_EN.
module mybullet_app
    import mybullet_app_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF,
    parameter int RANGE = RANGE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_4Hz,
    input  logic       bul_en,
    input  logic       bul_sht,
    input  logic [1:0] tank_dir,
    input  logic [4:0] tank_x,
    input  logic [4:0] tank_y,
    input  logic       bul_hit,
    output logic [4:0] bul_x,
    output logic [4:0] bul_y,
    output logic [1:0] bul_dir,
    output logic       mybul_state
);

    localparam logic [4:0] XM = X_MAX[4:0];
    localparam logic [4:0] YM = Y_MAX[4:0];

    bul_state_t r_state;
    logic [4:0] r_x;
    logic [4:0] r_y;
    logic [1:0] r_dir;

    logic       w_tick;
    logic [4:0] w_nx;
    logic [4:0] w_ny;
    logic       w_edge;
    logic       w_range_out;
    logic       w_launch;
    logic       w_retire;
    logic       w_step;

    edge_det u_tick (
        .clk   (clk),
        .rst   (rst),
        .din   (clk_4Hz),
        .pulse (w_tick)
    );

    // Candidate next cell; w_edge flags a step that would leave the field
    always_comb begin
        w_nx   = r_x;
        w_ny   = r_y;
        w_edge = 1'b0;
        case (r_dir)
            DIR_UP:    if (r_y >= YM)    w_edge = 1'b1; else w_ny = r_y + 5'd1;
            DIR_DOWN:  if (r_y == 5'd0)  w_edge = 1'b1; else w_ny = r_y - 5'd1;
            DIR_LEFT:  if (r_x >= XM)    w_edge = 1'b1; else w_nx = r_x + 5'd1;
            DIR_RIGHT: if (r_x == 5'd0)  w_edge = 1'b1; else w_nx = r_x - 5'd1;
        endcase
    end

`ifdef MYBUL_RANGE_EN
    localparam int CW = $clog2(RANGE + 2);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_launch) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One more step would push the count past RANGE
    assign w_range_out = (r_cnt >= RANGE[CW-1:0]);
`else
    logic w_unused_range;
    assign w_unused_range = |RANGE;
    assign w_range_out    = 1'b0;
`endif

    // Hit and enable loss take priority over a simultaneous tick
    assign w_launch = (r_state == IDLE) && bul_sht && bul_en;
    assign w_retire = (r_state == FLY) &&
                      (!bul_en || bul_hit || (w_tick && (w_edge || w_range_out)));
    assign w_step   = (r_state == FLY) && !w_retire && w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= PARK;
            r_y     <= PARK;
            r_dir   <= DIR_UP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= FLY;
                        r_x     <= tank_x;
                        r_y     <= tank_y;
                        r_dir   <= tank_dir;
                    end
                end
                FLY: begin
                    if (w_retire) begin
                        r_state <= IDLE;
                        r_x     <= PARK;
                        r_y     <= PARK;
                    end else if (w_step) begin
                        r_x <= w_nx;
                        r_y <= w_ny;
                    end
                end
            endcase
        end
    end

    assign bul_x       = r_x;
    assign bul_y       = r_y;
    assign bul_dir     = r_dir;
    assign mybul_state = (r_state == FLY);

endmodule

// File: tb/tb_mybullet_app.sv
// Directed bench for mybullet_app: launch, stepping, boundaries, hit priority, enable, reset.
module tb_mybullet_app;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_4Hz;
    logic       bul_en;
    logic       bul_sht;
    logic [1:0] tank_dir;
    logic [4:0] tank_x;
    logic [4:0] tank_y;
    logic       bul_hit;
    logic [4:0] bul_x;
    logic [4:0] bul_y;
    logic [1:0] bul_dir;
    logic       mybul_state;

    int checks   = 0;
    int failures = 0;

    mybullet_app dut (
        .clk         (clk),
        .rst         (rst),
        .clk_4Hz     (clk_4Hz),
        .bul_en      (bul_en),
        .bul_sht     (bul_sht),
        .tank_dir    (tank_dir),
        .tank_x      (tank_x),
        .tank_y      (tank_y),
        .bul_hit     (bul_hit),
        .bul_x       (bul_x),
        .bul_y       (bul_y),
        .bul_dir     (bul_dir),
        .mybul_state (mybul_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int x, input int y, input int d, input int s);
        check({tag, ".x"}, 32'(bul_x), x);
        check({tag, ".y"}, 32'(bul_y), y);
        check({tag, ".dir"}, 32'(bul_dir), d);
        check({tag, ".state"}, 32'(mybul_state), s);
    endtask

    task automatic fire(input int x, input int y, input int d);
        tank_x   = 5'(x);
        tank_y   = 5'(y);
        tank_dir = 2'(d);
        bul_en   = 1'b1;
        bul_sht  = 1'b1;
        step();
        bul_sht  = 1'b0;
    endtask

    // Rising edge on clk_4Hz, then the cycle in which the bullet consumes the tick
    task automatic tick();
        clk_4Hz = 1'b1;
        step();
        clk_4Hz = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; clk_4Hz = 1'b1; bul_en = 1'b0; bul_sht = 1'b0;
        tank_dir = 2'd0; tank_x = 5'd0; tank_y = 5'd0; bul_hit = 1'b0;
        step();
        step();
        expect_out("reset", 31, 31, 0, 0);

        // Launch right out of reset with clk_4Hz still high: no spurious motion
        rst = 1'b0;
        fire(5, 5, 0);
        expect_out("launch55", 5, 5, 0, 1);
        for (int i = 0; i < 3; i++) step();
        expect_out("held_high", 5, 5, 0, 1);
        clk_4Hz = 1'b0;
        step();

        tick();
        expect_out("tick1", 5, 6, 0, 1);
        tick();
        tick();
        expect_out("tick3", 5, 8, 0, 1);

        // Fire while in flight is ignored
        fire(1, 1, 3);
        expect_out("refire_fly", 5, 8, 0, 1);

        bul_hit = 1'b1;
        step();
        bul_hit = 1'b0;
        expect_out("hit", 31, 31, 0, 0);

        // Re-fire on the first cycle after retire
        fire(7, 10, 0);
        expect_out("refire_idle", 7, 10, 0, 1);

        // Hit and tick in the same cycle: hit wins
        clk_4Hz = 1'b1;
        step();
        clk_4Hz = 1'b0;
        bul_hit = 1'b1;
        step();
        bul_hit = 1'b0;
        expect_out("hit_tick", 31, 31, 0, 0);

        // Right from x=0 retires on first tick
        fire(0, 3, 3);
        expect_out("launch03", 0, 3, 3, 1);
        tick();
        expect_out("right_edge", 31, 31, 3, 0);

        // Up to Y_MAX then out
        fire(3, 18, 0);
        tick();
        expect_out("up_last", 3, 19, 0, 1);
        tick();
        expect_out("up_edge", 31, 31, 0, 0);

        // Left to X_MAX then out
        fire(14, 0, 2);
        tick();
        expect_out("left_last", 15, 0, 2, 1);
        tick();
        expect_out("left_edge", 31, 31, 2, 0);

        // Down to 0 then out
        fire(9, 1, 1);
        tick();
        expect_out("down_last", 9, 0, 1, 1);
        tick();
        expect_out("down_edge", 31, 31, 1, 0);

        // Enable low retires a flying bullet and blocks a fire in IDLE
        fire(6, 6, 1);
        bul_en = 1'b0;
        step();
        expect_out("en_low", 31, 31, 1, 0);
        bul_sht = 1'b1;
        step();
        bul_sht = 1'b0;
        check("fire_disabled.state", 32'(mybul_state), 0);
        bul_en = 1'b1;

        // Long flight from (2,0) upward
        fire(2, 0, 0);
        for (int i = 0; i < 8; i++) tick();
        expect_out("range8", 2, 8, 0, 1);
        tick();
`ifdef MYBUL_RANGE_EN
        expect_out("range9", 31, 31, 0, 0);
`else
        expect_out("range9", 2, 9, 0, 1);
        bul_en = 1'b0;
        step();
        bul_en = 1'b1;
`endif

        // Reset mid-flight, then relaunch with clk_4Hz held high
        fire(4, 4, 2);
        expect_out("launch44", 4, 4, 2, 1);
        rst = 1'b1;
        clk_4Hz = 1'b1;
        step();
        expect_out("rst_fly", 31, 31, 0, 0);
        rst = 1'b0;
        fire(4, 4, 2);
        for (int i = 0; i < 3; i++) step();
        expect_out("post_rst_high", 4, 4, 2, 1);
        clk_4Hz = 1'b0;
        step();
        tick();
        expect_out("post_rst_tick", 5, 4, 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
